// File: rtl/zone_mean_pkg.sv
// Shared types and default sizing for the zone mean sequencer and its divider lanes.
// No logic here; latency and backpressure are defined by the modules that import it.
// Build option ZONE_MEAN_ROUND_EN is consumed by zone_mean_div.
package zone_mean_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } zm_state_t;

    localparam int ZM_ZONES   = 16;
    localparam int ZM_SUM_W   = 17;
    localparam int ZM_MEAN_W  = 4;
    localparam int ZM_RECIP_W = 8;
    localparam int ZM_RSHIFT  = 16;

    // With RSHIFT=16 this approximates sum/7282.
    localparam int RECIP_DEFAULT = 9;

endpackage

// File: rtl/zone_mean_div.sv
// One channel of the mean divider: registered sum*recip, then shift/round/saturate.
// Latency: one register (product); mean_o is combinational from that register.
// No backpressure: en_i loads a new product every cycle it is high. Rounding via ZONE_MEAN_ROUND_EN.
module zone_mean_div #(
    parameter int SUM_W   = 17,
    parameter int RECIP_W = 8,
    parameter int RSHIFT  = 16,
    parameter int MEAN_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [SUM_W-1:0]   sum_i,
    input  logic [RECIP_W-1:0] recip_i,
    output logic [MEAN_W-1:0]  mean_o
);

    localparam int PW = SUM_W + RECIP_W;
    localparam logic [PW:0] MAXV = (PW+1)'((1 << MEAN_W) - 1);

    logic [PW-1:0] r_prod;
    logic [PW:0]   w_biased;
    logic [PW:0]   w_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else if (en_i) begin
            r_prod <= PW'(sum_i) * PW'(recip_i);
        end
    end

    // One extra bit of headroom so the rounding bias can never wrap.
`ifdef ZONE_MEAN_ROUND_EN
    assign w_biased = {1'b0, r_prod} + ((PW+1)'(1) << (RSHIFT - 1));
`else
    assign w_biased = {1'b0, r_prod};
`endif

    assign w_q    = w_biased >> RSHIFT;
    assign mean_o = (w_q > MAXV) ? {MEAN_W{1'b1}} : w_q[MEAN_W-1:0];

endmodule

// File: rtl/zone_mean_seq.sv
// Snapshots per-zone RGB sums on start, divides one zone per cycle, commits all means at once.
// Latency: done_o follows the accepted start edge by ZONES+2 edges; one frame per ZONES+3 cycles.
// No queuing: start_i while busy is discarded and flagged on drop_o. Rounding via ZONE_MEAN_ROUND_EN.
module zone_mean_seq
    import zone_mean_pkg::*;
#(
    parameter int ZONES   = ZM_ZONES,
    parameter int SUM_W   = ZM_SUM_W,
    parameter int MEAN_W  = ZM_MEAN_W,
    parameter int RECIP_W = ZM_RECIP_W,
    parameter int RSHIFT  = ZM_RSHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [RECIP_W-1:0] recip_i,
    input  logic [SUM_W-1:0]   SumR  [ZONES],
    input  logic [SUM_W-1:0]   SumG  [ZONES],
    input  logic [SUM_W-1:0]   SumB  [ZONES],
    output logic [MEAN_W-1:0]  MeanR [ZONES],
    output logic [MEAN_W-1:0]  MeanG [ZONES],
    output logic [MEAN_W-1:0]  MeanB [ZONES],
    output logic               busy_o,
    output logic               done_o,
    output logic               drop_o
);

    localparam int IDX_W = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ZONES - 1);

    zm_state_t          r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_idx1;
    logic               r_vld1;
    logic               r_busy;
    logic               r_done;
    logic               r_drop;
    logic [RECIP_W-1:0] r_recip;
    logic [SUM_W-1:0]   r_snap_r   [ZONES];
    logic [SUM_W-1:0]   r_snap_g   [ZONES];
    logic [SUM_W-1:0]   r_snap_b   [ZONES];
    logic [MEAN_W-1:0]  r_shadow_r [ZONES];
    logic [MEAN_W-1:0]  r_shadow_g [ZONES];
    logic [MEAN_W-1:0]  r_shadow_b [ZONES];
    logic [MEAN_W-1:0]  r_mean_r   [ZONES];
    logic [MEAN_W-1:0]  r_mean_g   [ZONES];
    logic [MEAN_W-1:0]  r_mean_b   [ZONES];

    logic               w_issue;
    logic [MEAN_W-1:0]  w_mean_r;
    logic [MEAN_W-1:0]  w_mean_g;
    logic [MEAN_W-1:0]  w_mean_b;

    assign w_issue = (r_state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            r_recip <= '0;
            for (int z = 0; z < ZONES; z++) begin
                r_snap_r[z] <= '0;
                r_snap_g[z] <= '0;
                r_snap_b[z] <= '0;
                r_mean_r[z] <= '0;
                r_mean_g[z] <= '0;
                r_mean_b[z] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        for (int z = 0; z < ZONES; z++) begin
                            r_snap_r[z] <= SumR[z];
                            r_snap_g[z] <= SumG[z];
                            r_snap_b[z] <= SumB[z];
                        end
                        r_recip <= recip_i;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_drop <= start_i;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    r_drop  <= start_i;
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    r_drop <= start_i;
                    for (int z = 0; z < ZONES; z++) begin
                        r_mean_r[z] <= r_shadow_r[z];
                        r_mean_g[z] <= r_shadow_g[z];
                        r_mean_b[z] <= r_shadow_b[z];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The zone index travels alongside the product so stage 2 knows where to write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1 <= 1'b0;
            r_idx1 <= '0;
            for (int z = 0; z < ZONES; z++) begin
                r_shadow_r[z] <= '0;
                r_shadow_g[z] <= '0;
                r_shadow_b[z] <= '0;
            end
        end else begin
            r_vld1 <= w_issue;
            r_idx1 <= r_idx;
            if (r_vld1) begin
                r_shadow_r[r_idx1] <= w_mean_r;
                r_shadow_g[r_idx1] <= w_mean_g;
                r_shadow_b[r_idx1] <= w_mean_b;
            end
        end
    end

    zone_mean_div #(.SUM_W(SUM_W), .RECIP_W(RECIP_W), .RSHIFT(RSHIFT), .MEAN_W(MEAN_W)) u_div_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_issue),
        .sum_i   (r_snap_r[r_idx]),
        .recip_i (r_recip),
        .mean_o  (w_mean_r)
    );

    zone_mean_div #(.SUM_W(SUM_W), .RECIP_W(RECIP_W), .RSHIFT(RSHIFT), .MEAN_W(MEAN_W)) u_div_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_issue),
        .sum_i   (r_snap_g[r_idx]),
        .recip_i (r_recip),
        .mean_o  (w_mean_g)
    );

    zone_mean_div #(.SUM_W(SUM_W), .RECIP_W(RECIP_W), .RSHIFT(RSHIFT), .MEAN_W(MEAN_W)) u_div_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_issue),
        .sum_i   (r_snap_b[r_idx]),
        .recip_i (r_recip),
        .mean_o  (w_mean_b)
    );

    assign MeanR  = r_mean_r;
    assign MeanG  = r_mean_g;
    assign MeanB  = r_mean_b;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign drop_o = r_drop;

endmodule

// File: tb/tb_zone_mean_seq.sv
// Randomised self-checking bench for zone_mean_seq against an arithmetic reference model.
module tb_zone_mean_seq;
    import zone_mean_pkg::*;

    localparam int ZONES   = ZM_ZONES;
    localparam int SUM_W   = ZM_SUM_W;
    localparam int MEAN_W  = ZM_MEAN_W;
    localparam int RECIP_W = ZM_RECIP_W;
    localparam int RSHIFT  = ZM_RSHIFT;
    localparam int MAXM    = (1 << MEAN_W) - 1;
    localparam int LAT     = ZONES + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic [RECIP_W-1:0] recip_i = '0;
    logic [SUM_W-1:0]   s_r [ZONES];
    logic [SUM_W-1:0]   s_g [ZONES];
    logic [SUM_W-1:0]   s_b [ZONES];
    logic [MEAN_W-1:0]  m_r [ZONES];
    logic [MEAN_W-1:0]  m_g [ZONES];
    logic [MEAN_W-1:0]  m_b [ZONES];
    logic               busy_o, done_o, drop_o;

    int errs = 0;
    int checks = 0;
    int c_r [ZONES];
    int c_g [ZONES];
    int c_b [ZONES];

    always #5 clk = ~clk;

    zone_mean_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .recip_i (recip_i),
        .SumR    (s_r),
        .SumG    (s_g),
        .SumB    (s_b),
        .MeanR   (m_r),
        .MeanG   (m_g),
        .MeanB   (m_b),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .drop_o  (drop_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mean_of(input longint sum, input longint rc);
        longint p;
        p = sum * rc;
`ifdef ZONE_MEAN_ROUND_EN
        p = p + (longint'(1) << (RSHIFT - 1));
`endif
        p = p / (longint'(1) << RSHIFT);
        return (p > MAXM) ? MAXM : int'(p);
    endfunction

    task automatic chk_means(input string tag);
        for (int z = 0; z < ZONES; z++) begin
            chk($sformatf("%s/R%0d", tag, z), 32'(m_r[z]), 32'(c_r[z]));
            chk($sformatf("%s/G%0d", tag, z), 32'(m_g[z]), 32'(c_g[z]));
            chk($sformatf("%s/B%0d", tag, z), 32'(m_b[z]), 32'(c_b[z]));
        end
    endtask

    task automatic set_all(input int v, input int rc);
        for (int z = 0; z < ZONES; z++) begin
            s_r[z] = SUM_W'(v);
            s_g[z] = SUM_W'(v);
            s_b[z] = SUM_W'(v);
        end
        recip_i = RECIP_W'(rc);
    endtask

    task automatic set_random(input int rc_max);
        for (int z = 0; z < ZONES; z++) begin
            s_r[z] = SUM_W'($urandom);
            s_g[z] = SUM_W'($urandom);
            s_b[z] = SUM_W'($urandom_range(0, 20000));
        end
        recip_i = RECIP_W'($urandom_range(0, rc_max));
    endtask

    // Called on a falling edge. drop_at >= 0 raises start_i in the cycle after edge T(drop_at).
    // chain leaves start_i high during the done cycle so the next frame starts immediately.
    task automatic frame(input string tag, input int drop_at, input bit chain);
        int e_r [ZONES];
        int e_g [ZONES];
        int e_b [ZONES];
        int n, drops, drop_edge, stale;
        bit seen;
        for (int z = 0; z < ZONES; z++) begin
            e_r[z] = mean_of(longint'(s_r[z]), longint'(recip_i));
            e_g[z] = mean_of(longint'(s_g[z]), longint'(recip_i));
            e_b[z] = mean_of(longint'(s_b[z]), longint'(recip_i));
        end
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, "/busy_run"}, 32'(busy_o), 32'd1);
        chk({tag, "/done_run"}, 32'(done_o), 32'd0);
        set_random(255);
        n = 0; seen = 1'b0; drops = 0; drop_edge = -1; stale = 0;
        while (!seen && n < 4 * LAT) begin
            start_i = (n == drop_at);
            @(posedge clk);
            n++;
            @(negedge clk);
            if (drop_o) begin
                drops++;
                drop_edge = n;
            end
            if (done_o) seen = 1'b1;
            else begin
                for (int z = 0; z < ZONES; z++)
                    if (32'(m_r[z]) != c_r[z] || 32'(m_g[z]) != c_g[z] || 32'(m_b[z]) != c_b[z])
                        stale++;
            end
        end
        start_i = chain;
        chk({tag, "/latency"}, 32'(n), 32'(LAT));
        chk({tag, "/busy_done"}, 32'(busy_o), 32'd0);
        chk({tag, "/early_change"}, 32'(stale), 32'd0);
        chk({tag, "/drops"}, 32'(drops), (drop_at >= 0) ? 32'd1 : 32'd0);
        if (drop_at >= 0) chk({tag, "/drop_edge"}, 32'(drop_edge), 32'(drop_at + 1));
        c_r = e_r;
        c_g = e_g;
        c_b = e_b;
        chk_means(tag);
        if (!chain) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "/done_pulse"}, 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        int dones;
        set_all(0, RECIP_DEFAULT);
        #2;
        chk_means("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle/busy", 32'(busy_o), 32'd0);
        chk("idle/done", 32'(done_o), 32'd0);
        chk("idle/drop", 32'(drop_o), 32'd0);
        chk_means("idle");

        set_all(65535, RECIP_DEFAULT);
        frame("full9", -1, 1'b0);
        chk("full9/zone0", 32'(m_r[0]), mean_of(65535, 9));

        for (int z = 0; z < ZONES; z++) begin
            s_r[z] = SUM_W'(z * 4096);
            s_g[z] = SUM_W'(z * 4096);
            s_b[z] = SUM_W'((ZONES - 1 - z) * 4096);
        end
        recip_i = RECIP_W'(RECIP_DEFAULT);
        frame("ramp", -1, 1'b0);

        set_all(65535, 255);
        frame("sat", -1, 1'b0);
        set_all(0, 255);
        frame("zero", -1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            set_random((i < 2) ? 20 : 255);
            frame($sformatf("rand%0d", i), -1, 1'b0);
        end

        set_random(20);
        frame("drop", 5, 1'b0);

        set_random(20);
        frame("chain_a", -1, 1'b1);
        frame("chain_b", -1, 1'b0);

        set_all(65535, 255);
        frame("pre_rst", -1, 1'b0);
        set_random(20);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int z = 0; z < ZONES; z++) begin
            c_r[z] = 0;
            c_g[z] = 0;
            c_b[z] = 0;
        end
        chk_means("midrst");
        chk("midrst/busy", 32'(busy_o), 32'd0);
        chk("midrst/done", 32'(done_o), 32'd0);
        chk("midrst/drop", 32'(drop_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_o || busy_o) dones++;
        end
        chk("midrst/no_activity", 32'(dones), 32'd0);

        set_random(20);
        frame("post_rst", -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
